mem_arbiter: RTL and testbench

- Shares one single-port memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the fetch/memory stages and the memory model.
- The data port has priority, with bounded fetch starvation.
- Tracks outstanding reads in an in-order tag FIFO so each response is routed to the requester that issued it.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (D) requesters.
// D has priority with bounded IF starvation; an in-order tag FIFO routes read responses.
module mem_arbiter #(
  parameter int AWIDTH          = 32,
  parameter int DWIDTH          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_STREAK      = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 if_req_i,
  input  logic [AWIDTH-1:0]                    if_addr_i,
  output logic                                 if_gnt_o,
  output logic                                 if_rvalid_o,
  output logic [DWIDTH-1:0]                    if_rdata_o,
  input  logic                                 d_req_i,
  input  logic                                 d_we_i,
  input  logic [AWIDTH-1:0]                    d_addr_i,
  input  logic [DWIDTH-1:0]                    d_wdata_i,
  input  logic [DWIDTH/8-1:0]                  d_be_i,
  output logic                                 d_gnt_o,
  output logic                                 d_rvalid_o,
  output logic [DWIDTH-1:0]                    d_rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [AWIDTH-1:0]                    mem_addr_o,
  output logic [DWIDTH-1:0]                    mem_wdata_o,
  output logic [DWIDTH/8-1:0]                  mem_be_o,
  input  logic                                 mem_ready_i,
  input  logic                                 mem_rvalid_i,
  input  logic [DWIDTH-1:0]                    mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic TAG_IF = 1'b0;
  localparam logic TAG_D  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic [SW-1:0]              streak_q;
  logic                       err_q;

  logic full, empty, pop, push, read_ok;
  logic if_elig, d_elig, prefer_if, sel_if, sel_d, any_sel, head_tag;

  assign full     = (count_q == CW'(MAX_OUTSTANDING));
  assign empty    = (count_q == '0);
  assign pop      = mem_rvalid_i && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a read.
  assign read_ok  = !full || pop;
  assign if_elig  = if_req_i && read_ok;
  assign d_elig   = d_req_i && (d_we_i || read_ok);
  assign prefer_if = if_req_i && (!d_req_i || (streak_q == SW'(MAX_STREAK)));

  always_comb begin
    sel_if = 1'b0;
    sel_d  = 1'b0;
    if (prefer_if) begin
      if (if_elig)     sel_if = 1'b1;
      else if (d_elig) sel_d  = 1'b1;
    end else begin
      if (d_elig)       sel_d  = 1'b1;
      else if (if_elig) sel_if = 1'b1;
    end
  end

  // Handshake outputs are held low while reset is asserted.
  assign any_sel     = (sel_if || sel_d) && rst_ni;
  assign mem_req_o   = any_sel;
  assign mem_we_o    = sel_d && d_we_i;
  assign mem_addr_o  = sel_d ? d_addr_i : if_addr_i;
  assign mem_wdata_o = sel_d ? d_wdata_i : '0;
  assign mem_be_o    = sel_d ? d_be_i : '1;
  assign if_gnt_o    = any_sel && sel_if && mem_ready_i;
  assign d_gnt_o     = any_sel && sel_d && mem_ready_i;
  assign push        = if_gnt_o || (d_gnt_o && !d_we_i);

  assign head_tag    = tag_q[rd_ptr_q];
  assign if_rvalid_o = pop && rst_ni && (head_tag == TAG_IF);
  assign d_rvalid_o  = pop && rst_ni && (head_tag == TAG_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= d_gnt_o ? TAG_D : TAG_IF;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      if (mem_rvalid_i && empty) err_q <= 1'b1;

      if (if_gnt_o || !if_req_i)
        streak_q <= '0;
      else if (d_gnt_o && streak_q != SW'(MAX_STREAK))
        streak_q <= streak_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for
// async reset mid-stream and late-response error flagging.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] IA = 32'h100;
  localparam logic [31:0] DA = 32'h200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [3:0] d_be, mem_be;
  logic mem_req, mem_we, mem_ready, mem_rvalid, err;
  logic [2:0] outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(4), .MAX_STREAK(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_be_i(d_be), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ready_i(mem_ready),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dwe; logic [31:0] da; logic [31:0] dwd; logic [3:0] dbe;
    logic        rdy; logic rv;  logic [31:0] rd;
    logic        e_ig, e_dg, e_irv, e_drv, e_mr, e_mwe;
    logic [31:0] e_ma;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                     input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic e_ig, input logic e_dg, input logic e_irv, input logic e_drv,
                     input logic e_mr, input logic e_mwe, input logic [31:0] e_ma,
                     input logic [2:0] e_out, input logic e_err);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dbe = dbe;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_mr = e_mr; v.e_mwe = e_mwe; v.e_ma = e_ma; v.e_out = e_out; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = IA; d_req = 0; d_we = 0; d_addr = DA; d_wdata = '0; d_be = 4'hF;
    mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    // both request D reads; responses from c1 keep one read in flight
    add(1,IA,1,0,DA,0,4'hF, 1,0,32'h0,        0,1,0,0,1,0,DA,0,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h1,        0,1,0,1,1,0,DA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h2,        0,1,0,1,1,0,DA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h3,        1,0,0,1,1,0,IA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h4,        0,1,1,0,1,0,DA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h5,        0,1,0,1,1,0,DA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h6,        0,1,0,1,1,0,DA,1,0);
    add(1,IA,1,0,DA,0,4'hF, 1,1,32'h7,        1,0,0,1,1,0,IA,1,0);
    add(0,IA,0,0,DA,0,4'hF, 1,1,32'h9,        0,0,1,0,0,0,0,1,0);
    // IF then D read, in-order routed responses
    add(1,IA,0,0,DA,0,4'hF, 1,0,32'h0,        1,0,0,0,1,0,IA,0,0);
    add(0,IA,1,0,DA,0,4'hF, 1,0,32'h0,        0,1,0,0,1,0,DA,1,0);
    add(0,IA,0,0,DA,0,4'hF, 1,1,32'hAAAA0000, 0,0,1,0,0,0,0,2,0);
    add(0,IA,0,0,DA,0,4'hF, 1,1,32'h5555FFFF, 0,0,0,1,0,0,0,1,0);
    add(0,IA,0,0,DA,0,4'hF, 1,0,32'h0,        0,0,0,0,0,0,0,0,0);
    // fill FIFO with IF reads, then store still passes while IF is blocked
    for (int k = 0; k < 4; k++)
      add(1,IA,0,0,DA,0,4'hF, 1,0,32'h0,      1,0,0,0,1,0,IA,3'(k),0);
    add(1,IA,1,1,32'h300,32'hDEADBEEF,4'hF, 1,0,32'h0, 0,1,0,0,1,1,32'h300,4,0);
    add(1,IA,0,0,DA,0,4'hF, 1,0,32'h0,        0,0,0,0,0,0,0,4,0);
    // full FIFO: pop and new IF read in the same cycle
    add(1,IA,0,0,DA,0,4'hF, 1,1,32'h11112222, 1,0,1,0,1,0,IA,4,0);
    for (int k = 4; k > 0; k--)
      add(0,IA,0,0,DA,0,4'hF, 1,1,32'h40+k,   0,0,1,0,0,0,0,3'(k),0);
    // memory stalls: request held with D fields, no grant
    for (int k = 0; k < 3; k++)
      add(1,IA,1,0,DA,0,4'hF, 0,0,32'h0,      0,0,0,0,1,0,DA,0,0);
    add(1,IA,1,0,DA,0,4'hF, 1,0,32'h0,        0,1,0,0,1,0,DA,0,0);
    add(0,IA,0,0,DA,0,4'hF, 1,1,32'hCAFE0001, 0,0,0,1,0,0,0,1,0);
    // response with nothing outstanding
    add(0,IA,0,0,DA,0,4'hF, 1,1,32'hBAD0BAD0, 0,0,0,0,0,0,0,0,0);
    add(0,IA,0,0,DA,0,4'hF, 1,0,32'h0,        0,0,0,0,0,0,0,0,1);
    add(0,IA,0,0,DA,0,4'hF, 1,0,32'h0,        0,0,0,0,0,0,0,0,1);

    #2;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 0);
    chk("reset_mem_req", mem_req, 0);
    #20 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      if_req = vecs[i].ir; if_addr = vecs[i].ia; d_req = vecs[i].dr; d_we = vecs[i].dwe;
      d_addr = vecs[i].da; d_wdata = vecs[i].dwd; d_be = vecs[i].dbe;
      mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i), if_gnt, vecs[i].e_ig);
      chk($sformatf("v%0d d_gnt", i), d_gnt, vecs[i].e_dg);
      chk($sformatf("v%0d if_rvalid", i), if_rvalid, vecs[i].e_irv);
      chk($sformatf("v%0d d_rvalid", i), d_rvalid, vecs[i].e_drv);
      chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_mr);
      chk($sformatf("v%0d outstanding", i), outstanding, vecs[i].e_out);
      chk($sformatf("v%0d err", i), err, vecs[i].e_err);
      if (vecs[i].e_mr) begin
        chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_mwe);
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_ma);
      end
      if (vecs[i].e_mwe) begin
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].dwd);
        chk($sformatf("v%0d mem_be", i), mem_be, vecs[i].dbe);
      end
      if (vecs[i].e_ig) chk($sformatf("v%0d mem_be_fetch", i), mem_be, 4'hF);
      if (vecs[i].e_irv) chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].rd);
      if (vecs[i].e_drv) chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].rd);
    end

    // two reads in flight, then async reset mid-cycle while requesting
    @(posedge clk); #1;
    idle_inputs(); if_req = 1;
    @(posedge clk); #1;
    if_req = 0; d_req = 1;
    @(posedge clk); #1;
    d_req = 0; if_req = 1; mem_ready = 1;
    @(negedge clk);
    chk("pre_reset_outstanding", outstanding, 2);
    chk("pre_reset_err", err, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_outstanding", outstanding, 0);
    chk("async_err", err, 0);
    chk("async_mem_req", mem_req, 0);
    chk("async_if_gnt", if_gnt, 0);
    mem_rvalid = 1;
    #1;
    chk("async_if_rvalid", if_rvalid, 0);
    chk("async_d_rvalid", d_rvalid, 0);
    idle_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    // late response from before reset
    @(posedge clk); #1 mem_rvalid = 1; mem_rdata = 32'h1A7E;
    @(negedge clk);
    chk("late_if_rvalid", if_rvalid, 0);
    chk("late_d_rvalid", d_rvalid, 0);
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
    chk("late_err", err, 1);
    chk("late_outstanding", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
